uart_byte_tx: RTL and testbench

//  UART transmitter: serialises one byte per valid/ready handshake onto tx_pin.

---
 rtl/uart_byte_tx.sv | 130 +++++++++++++
 tb/tb_uart_byte_tx.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/uart_byte_tx.sv
// UART byte transmitter: one byte per valid/ready handshake, start + 8 data (LSB first)
// + optional parity + 1 or 2 stop bits, bit time derived from the system clock.
module uart_byte_tx #(
  parameter int CLK_FRE   = 50,
  parameter int BAUD_RATE = 115200,
  parameter int PARITY    = 0,
  parameter int STOP_BITS = 1
) (
  input  logic       sys_clk,
  input  logic       rst,
  input  logic [7:0] tx_data,
  input  logic       tx_data_valid,
  output logic       tx_data_ready,
  output logic       tx_busy,
  output logic       tx_pin
);

  localparam int CYCLE     = CLK_FRE * 1000000 / BAUD_RATE;
  localparam int CNT_W     = $clog2(CYCLE * 2);
  localparam bit PAR_EN    = (PARITY == 1) || (PARITY == 2);
  localparam bit PAR_ODD   = (PARITY == 1);
  localparam int STOP_CLKS = (STOP_BITS == 2) ? 2 * CYCLE : CYCLE;

  localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CYCLE - 1);
  localparam logic [CNT_W-1:0] STOP_LAST = CNT_W'(STOP_CLKS - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PARITY,
    S_STOP
  } state_t;

  state_t           state, state_next;
  logic [CNT_W-1:0] baud_cnt, baud_next;
  logic [2:0]       bit_cnt, bit_next;
  logic [7:0]       data_reg;
  logic             pin_next, ready_next, busy_next;
  logic             accept;
  logic             par_bit;

  assign accept  = tx_data_valid && tx_data_ready;
  assign par_bit = PAR_ODD ? ~^data_reg : ^data_reg;

  always_ff @(posedge sys_clk) begin
    if (rst) begin
      state         <= S_IDLE;
      baud_cnt      <= '0;
      bit_cnt       <= '0;
      data_reg      <= '0;
      tx_pin        <= 1'b1;
      tx_data_ready <= 1'b0;
      tx_busy       <= 1'b0;
    end else begin
      state         <= state_next;
      baud_cnt      <= baud_next;
      bit_cnt       <= bit_next;
      tx_pin        <= pin_next;
      tx_data_ready <= ready_next;
      tx_busy       <= busy_next;
      if (accept) begin
        data_reg <= tx_data;
      end
    end
  end

  // The baud counter restarts on every state change and on every data bit advance.
  always_comb begin
    state_next = state;
    baud_next  = baud_cnt + 1'b1;
    bit_next   = bit_cnt;
    case (state)
      S_IDLE: begin
        baud_next = '0;
        bit_next  = '0;
        if (accept) begin
          state_next = S_START;
        end
      end
      S_START: begin
        if (baud_cnt == BIT_LAST) begin
          state_next = S_DATA;
          baud_next  = '0;
        end
      end
      S_DATA: begin
        if (baud_cnt == BIT_LAST) begin
          baud_next = '0;
          if (bit_cnt == 3'd7) begin
            state_next = PAR_EN ? S_PARITY : S_STOP;
          end else begin
            bit_next = bit_cnt + 1'b1;
          end
        end
      end
      S_PARITY: begin
        if (baud_cnt == BIT_LAST) begin
          state_next = S_STOP;
          baud_next  = '0;
        end
      end
      S_STOP: begin
        if (baud_cnt == STOP_LAST) begin
          state_next = S_IDLE;
          baud_next  = '0;
        end
      end
      default: begin
        state_next = S_IDLE;
        baud_next  = '0;
        bit_next   = '0;
      end
    endcase
  end

  // Outputs are computed from the upcoming state so the registered line lands on the bit boundary.
  always_comb begin
    pin_next = 1'b1;
    case (state_next)
      S_START:  pin_next = 1'b0;
      S_DATA:   pin_next = data_reg[bit_next];
      S_PARITY: pin_next = par_bit;
      default:  pin_next = 1'b1;
    endcase
    ready_next = (state_next == S_IDLE);
    busy_next  = (state_next != S_IDLE);
  end

endmodule

// File: tb/tb_uart_byte_tx.sv
// Self-checking bench for uart_byte_tx: four parameter variants, a frame-level reference
// model, directed vector table, back-to-back / busy / mid-frame reset sequences and random bytes.
`timescale 1ns/1ps
module tb_uart_byte_tx;

  localparam int CYC = 434;

  logic       sys_clk = 1'b0;
  logic       rst = 1'b1;
  logic [3:0] valid_v = '0;
  logic [7:0] data_v [4];
  logic       ready0, ready1, ready2, ready3;
  logic       busy0, busy1, busy2, busy3;
  logic       pin0, pin1, pin2, pin3;
  logic [3:0] ready_v, busy_v, pin_v;
  longint     cyc = 0;
  int         n_cmp = 0;
  int         n_fail = 0;

  assign ready_v = {ready3, ready2, ready1, ready0};
  assign busy_v  = {busy3, busy2, busy1, busy0};
  assign pin_v   = {pin3, pin2, pin1, pin0};

  always #10 sys_clk = ~sys_clk;

  always @(posedge sys_clk) cyc <= cyc + 1;

  uart_byte_tx u0 (
    .sys_clk(sys_clk), .rst(rst), .tx_data(data_v[0]), .tx_data_valid(valid_v[0]),
    .tx_data_ready(ready0), .tx_busy(busy0), .tx_pin(pin0));
  uart_byte_tx #(.PARITY(1)) u1 (
    .sys_clk(sys_clk), .rst(rst), .tx_data(data_v[1]), .tx_data_valid(valid_v[1]),
    .tx_data_ready(ready1), .tx_busy(busy1), .tx_pin(pin1));
  uart_byte_tx #(.PARITY(2)) u2 (
    .sys_clk(sys_clk), .rst(rst), .tx_data(data_v[2]), .tx_data_valid(valid_v[2]),
    .tx_data_ready(ready2), .tx_busy(busy2), .tx_pin(pin2));
  uart_byte_tx #(.STOP_BITS(2)) u3 (
    .sys_clk(sys_clk), .rst(rst), .tx_data(data_v[3]), .tx_data_valid(valid_v[3]),
    .tx_data_ready(ready3), .tx_busy(busy3), .tx_pin(pin3));

  function automatic int par_mode(input int idx);
    return (idx == 1) ? 1 : (idx == 2) ? 2 : 0;
  endfunction

  function automatic int frame_slots(input int idx);
    return 1 + 8 + ((par_mode(idx) != 0) ? 1 : 0) + ((idx == 3) ? 2 : 1);
  endfunction

  // Reference line level for bit slot k of a frame carrying byte b.
  function automatic logic frame_bit(input int idx, input logic [7:0] b, input int k);
    int ones;
    ones = $countones(b);
    if (k == 0) return 1'b0;
    if (k >= 1 && k <= 8) return b[k-1];
    if (k == 9 && par_mode(idx) == 2) return logic'(ones % 2);
    if (k == 9 && par_mode(idx) == 1) return logic'(1 - (ones % 2));
    return 1'b1;
  endfunction

  task automatic checkOutput(input string name, input longint act, input longint exp);
    n_cmp++;
    if (act != exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic applyStimulus(input int idx, input logic [7:0] b, input logic [7:0] after_b,
                               input bit hold, input bit pulse, output int len,
                               output logic [7:0] dec, output int par_s, output longint acc,
                               output int tail_hi);
    int n, k, pin_err, rdy_err, slots, wait_n, last_low;
    wait_n = 0;
    while (!ready_v[idx] && wait_n < 50) begin
      @(negedge sys_clk);
      wait_n++;
    end
    checkOutput("ready_before_accept", longint'(ready_v[idx]), 1);
    data_v[idx]  = b;
    valid_v[idx] = 1'b1;
    @(negedge sys_clk);
    acc         = cyc;
    data_v[idx] = after_b;
    if (!hold) valid_v[idx] = 1'b0;
    slots    = frame_slots(idx);
    n        = 0;
    pin_err  = 0;
    rdy_err  = 0;
    dec      = '0;
    par_s    = -1;
    last_low = -1;
    while (busy_v[idx] === 1'b1 && n < slots * CYC + CYC) begin
      if (pin_v[idx] !== frame_bit(idx, b, n / CYC)) pin_err++;
      if (ready_v[idx] !== 1'b0) rdy_err++;
      if (pin_v[idx] === 1'b0) last_low = n;
      if (n % CYC == CYC / 2) begin
        k = n / CYC;
        if (k >= 1 && k <= 8) dec[k-1] = pin_v[idx];
        if (k == 9 && par_mode(idx) != 0) par_s = int'(pin_v[idx]);
      end
      if (pulse && n == 2000) begin
        data_v[idx]  = 8'hFF;
        valid_v[idx] = 1'b1;
      end
      if (pulse && n == 2001) begin
        data_v[idx]  = after_b;
        valid_v[idx] = 1'b0;
      end
      n++;
      @(negedge sys_clk);
    end
    len     = n;
    tail_hi = n - (last_low + 1);
    checkOutput("pin_trace_errors", pin_err, 0);
    checkOutput("ready_low_in_frame", rdy_err, 0);
    checkOutput("frame_len", len, slots * CYC);
    checkOutput("decoded_byte", dec, b);
    checkOutput("ready_after_frame", longint'(ready_v[idx]), 1);
    checkOutput("pin_idle_after_frame", longint'(pin_v[idx]), 1);
  endtask

  typedef struct {
    int         inst;
    logic [7:0] data;
    int         exp_par;
    int         exp_len;
    int         exp_tail;
  } vec_t;

  initial begin
    vec_t       tbl[4];
    int         len, par_s, tail, idx;
    logic [7:0] dec, b;
    longint     acc1, acc2;

    for (int i = 0; i < 4; i++) data_v[i] = '0;

    tbl[0] = '{0, 8'hA3, -1, 10 * CYC, 2 * CYC};
    tbl[1] = '{1, 8'hA3,  1, 11 * CYC, 3 * CYC};
    tbl[2] = '{2, 8'hA3,  0, 11 * CYC, 1 * CYC};
    tbl[3] = '{3, 8'h23, -1, 11 * CYC, 2 * CYC};

    rst = 1'b1;
    repeat (5) @(negedge sys_clk);
    for (int i = 0; i < 4; i++) begin
      checkOutput("reset_pin", longint'(pin_v[i]), 1);
      checkOutput("reset_ready", longint'(ready_v[i]), 0);
      checkOutput("reset_busy", longint'(busy_v[i]), 0);
    end
    rst = 1'b0;
    @(negedge sys_clk);
    for (int i = 0; i < 4; i++) checkOutput("ready_after_release", longint'(ready_v[i]), 1);

    for (int i = 0; i < 4; i++) begin
      applyStimulus(tbl[i].inst, tbl[i].data, ~tbl[i].data, 1'b0, 1'b0, len, dec, par_s, acc1, tail);
      checkOutput("tbl_len", len, tbl[i].exp_len);
      checkOutput("tbl_tail_high", tail, tbl[i].exp_tail);
      if (tbl[i].exp_par >= 0) checkOutput("tbl_parity", par_s, tbl[i].exp_par);
    end

    // Valid held high across two frames: the second accept follows one idle clock.
    applyStimulus(0, 8'h55, 8'h0F, 1'b1, 1'b0, len, dec, par_s, acc1, tail);
    applyStimulus(0, 8'h0F, 8'hF0, 1'b0, 1'b0, len, dec, par_s, acc2, tail);
    checkOutput("b2b_gap", acc2 - acc1, 10 * CYC + 1);

    applyStimulus(0, 8'h3C, 8'hC3, 1'b0, 1'b1, len, dec, par_s, acc1, tail);
    repeat (5) @(negedge sys_clk);
    checkOutput("no_queued_frame_busy", longint'(busy_v[0]), 0);
    checkOutput("no_queued_frame_pin", longint'(pin_v[0]), 1);

    // Reset in the middle of data bit 3 (a zero bit, so the return to idle is visible).
    data_v[0]  = 8'hF7;
    valid_v[0] = 1'b1;
    @(negedge sys_clk);
    valid_v[0] = 1'b0;
    repeat (4 * CYC + 200) @(negedge sys_clk);
    checkOutput("pin_before_reset", longint'(pin_v[0]), 0);
    rst = 1'b1;
    @(negedge sys_clk);
    checkOutput("midreset_pin", longint'(pin_v[0]), 1);
    checkOutput("midreset_busy", longint'(busy_v[0]), 0);
    checkOutput("midreset_ready", longint'(ready_v[0]), 0);
    rst = 1'b0;
    @(negedge sys_clk);
    checkOutput("midreset_ready_release", longint'(ready_v[0]), 1);
    applyStimulus(0, 8'h81, 8'h7E, 1'b0, 1'b0, len, dec, par_s, acc1, tail);

    for (int r = 0; r < 3; r++) begin
      idx = int'($urandom_range(0, 3));
      b   = 8'($urandom_range(0, 255));
      applyStimulus(idx, b, 8'($urandom), 1'b0, 1'b0, len, dec, par_s, acc1, tail);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #3_000_000;
    $display("[TB] FAIL global_timeout: got running, expected finished");
    $fatal(1, "[TB] time limit reached");
  end

endmodule
